// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: flag bit map, opcodes,
// jump conditions, FSM states and instruction field positions.
package ctrl_pkg;

  localparam int FLAG_AI     = 0;
  localparam int FLAG_BI     = 1;
  localparam int FLAG_CI     = 2;
  localparam int FLAG_DI     = 3;
  localparam int FLAG_EI     = 4;
  localparam int FLAG_FI     = 5;
  localparam int FLAG_GI     = 6;
  localparam int FLAG_HI     = 7;
  localparam int FLAG_RAMI   = 8;
  localparam int FLAG_MARI   = 9;
  localparam int FLAG_MPAGEI = 10;
  localparam int FLAG_OUTI   = 11;
  localparam int FLAG_AO     = 12;
  localparam int FLAG_BO     = 13;
  localparam int FLAG_CO     = 14;
  localparam int FLAG_DO     = 15;
  localparam int FLAG_EO     = 16;
  localparam int FLAG_FO     = 17;
  localparam int FLAG_GO     = 18;
  localparam int FLAG_HO     = 19;
  localparam int FLAG_ALUO   = 20;
  localparam int FLAG_ROMO   = 21;
  localparam int FLAG_RAMO   = 22;
  localparam int FLAG_JMP    = 23;
  localparam int FLAG_IO     = 24;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int DST_MSB   = 11;
  localparam int DST_LSB   = 8;
  localparam int SRC_MSB   = 7;
  localparam int SRC_LSB   = 4;
  localparam int ALUOP_MSB = 3;
  localparam int ALUOP_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_MOV  = 4'h1,
    OP_ALU  = 4'h2,
    OP_LDI  = 4'h3,
    OP_JMP  = 4'h4,
    OP_HALT = 4'hF
  } opcode_t;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_Z      = 4'd1;
  localparam logic [3:0] COND_NZ     = 4'd2;
  localparam logic [3:0] COND_C      = 4'd3;
  localparam logic [3:0] COND_NC     = 4'd4;
  localparam logic [3:0] COND_N      = 4'd5;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_OPERAND = 3'd2,
    ST_EXEC    = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  // Codes 6-15 never jump.
  function automatic logic condMet(input logic [3:0] cond, input logic z,
                                   input logic c, input logic n);
    case (cond)
      COND_ALWAYS: condMet = 1'b1;
      COND_Z:      condMet = z;
      COND_NZ:     condMet = ~z;
      COND_C:      condMet = c;
      COND_NC:     condMet = ~c;
      COND_N:      condMet = n;
      default:     condMet = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/flag_decoder.sv
// Combinational decode of the instruction register into control flags,
// register write strobe and ALU operation; all outputs are zero outside EXEC.
module flag_decoder
  import ctrl_pkg::*;
#(
  parameter int FLAGS_LEN = 25
) (
  input  logic [15:0]          i_ir,
  input  logic                 i_inExec,
  output logic [FLAGS_LEN-1:0] o_flags,
  output logic                 o_writeEn,
  output logic [3:0]           o_aluOp
);

  logic [3:0]  w_op;
  logic [3:0]  w_dst;
  logic [3:0]  w_src;
  logic [11:0] w_inSel;
  logic [12:0] w_outSel;

  assign w_op  = i_ir[OP_MSB:OP_LSB];
  assign w_dst = i_ir[DST_MSB:DST_LSB];
  assign w_src = i_ir[SRC_MSB:SRC_LSB];

  // Out-of-range dst/src codes select no flag at all.
  always_comb begin
    w_inSel  = '0;
    w_outSel = '0;
    if (w_dst <= 4'd11) w_inSel = 12'd1 << w_dst;
    if (w_src <= 4'd12) w_outSel = 13'd1 << w_src;
  end

  always_comb begin
    o_flags   = '0;
    o_writeEn = 1'b0;
    o_aluOp   = 4'd0;
    if (i_inExec) begin
      case (w_op)
        OP_MOV: begin
          o_flags[FLAG_OUTI:FLAG_AI] = w_inSel;
          o_flags[FLAG_IO:FLAG_AO]   = w_outSel;
          o_writeEn                  = 1'b1;
        end
        OP_ALU: begin
          o_flags[FLAG_OUTI:FLAG_AI] = w_inSel;
          o_flags[FLAG_IO:FLAG_AO]   = w_outSel;
          o_flags[FLAG_ALUO]         = 1'b1;
          o_aluOp                    = i_ir[ALUOP_MSB:ALUOP_LSB];
          o_writeEn                  = 1'b1;
        end
        OP_LDI: begin
          o_flags[FLAG_OUTI:FLAG_AI] = w_inSel;
          o_flags[FLAG_ROMO]         = 1'b1;
          o_writeEn                  = 1'b1;
        end
        OP_JMP: o_flags[FLAG_JMP] = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction fetch/decode/execute sequencer owning PC, IR and ALU status.
// Optional feature: define SINGLE_STEP_EN to hold FETCH until step is high.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int          FLAGS_LEN = 25,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          rom,
  output logic [15:0]          rom_addr,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  input  logic                 alu_neg,
  input  logic                 step,
  output logic [FLAGS_LEN-1:0] flags,
  output logic                 write_en,
  output logic [3:0]           alu_op,
  output logic                 halted
);

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        r_statusZ;
  logic        r_statusC;
  logic        r_statusN;
  logic        w_inExec;
  logic [3:0]  w_romOp;
  logic [3:0]  w_irOp;
  logic [15:0] w_pcInc;

  assign w_romOp  = rom[OP_MSB:OP_LSB];
  assign w_irOp   = r_ir[OP_MSB:OP_LSB];
  assign w_pcInc  = r_pc + 16'd1;
  assign rom_addr = r_pc;

`ifndef SINGLE_STEP_EN
  logic w_unusedStep;
  assign w_unusedStep = step;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
`ifdef SINGLE_STEP_EN
      ST_FETCH:   w_nextState = step ? ST_DECODE : ST_FETCH;
`else
      ST_FETCH:   w_nextState = ST_DECODE;
`endif
      ST_DECODE: begin
        case (w_romOp)
          OP_LDI, OP_JMP: w_nextState = ST_OPERAND;
          OP_HALT:        w_nextState = ST_HALT;
          default:        w_nextState = ST_EXEC;
        endcase
      end
      ST_OPERAND: w_nextState = ST_EXEC;
      ST_EXEC:    w_nextState = ST_FETCH;
      ST_HALT:    w_nextState = ST_HALT;
      default:    w_nextState = ST_FETCH;
    endcase
  end

  always_comb begin
    w_inExec = (r_state == ST_EXEC);
    halted   = (r_state == ST_HALT);
  end

  // In EXEC of a two-word instruction, rom already holds the operand word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_ir      <= 16'h0000;
      r_statusZ <= 1'b0;
      r_statusC <= 1'b0;
      r_statusN <= 1'b0;
    end else begin
      case (r_state)
        ST_DECODE: begin
          r_ir <= rom;
          r_pc <= w_pcInc;
        end
        ST_EXEC: begin
          case (w_irOp)
            OP_LDI: r_pc <= w_pcInc;
            OP_JMP: begin
              if (condMet(r_ir[DST_MSB:DST_LSB], r_statusZ, r_statusC, r_statusN))
                r_pc <= rom;
              else
                r_pc <= w_pcInc;
            end
            OP_ALU: begin
              r_statusZ <= alu_zero;
              r_statusC <= alu_carry;
              r_statusN <= alu_neg;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  flag_decoder #(
    .FLAGS_LEN(FLAGS_LEN)
  ) u_flagDecoder (
    .i_ir     (r_ir),
    .i_inExec (w_inExec),
    .o_flags  (flags),
    .o_writeEn(write_en),
    .o_aluOp  (alu_op)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer with a behavioural
// synchronous ROM; a second instance covers PC wrap from RESET_PC=FFFF.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aluZero = 1'b0;
  logic        aluCarry = 1'b0;
  logic        aluNeg = 1'b0;
  logic        step = 1'b0;

  logic [15:0] romData, romAddr;
  logic [24:0] flags;
  logic        writeEn, halted;
  logic [3:0]  aluOp;

  logic [15:0] romDataW, romAddrW;
  logic [24:0] flagsW;
  logic        writeEnW, haltedW;
  logic [3:0]  aluOpW;

  logic [15:0] mem [0:65535];

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    romData  <= mem[romAddr];
    romDataW <= mem[romAddrW];
  end

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .rom(romData), .rom_addr(romAddr),
    .alu_zero(aluZero), .alu_carry(aluCarry), .alu_neg(aluNeg), .step(step),
    .flags(flags), .write_en(writeEn), .alu_op(aluOp), .halted(halted)
  );

  control_sequencer #(.RESET_PC(16'hFFFF)) dutWrap (
    .clk(clk), .rst_n(rst_n), .rom(romDataW), .rom_addr(romAddrW),
    .alu_zero(aluZero), .alu_carry(aluCarry), .alu_neg(aluNeg), .step(step),
    .flags(flagsW), .write_en(writeEnW), .alu_op(aluOpW), .halted(haltedW)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the start of cycle 1 (FETCH) with reset released.
  task automatic applyReset();
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3);
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    mem[16'h0040] = 16'h0000;
    mem[16'hFFFF] = 16'h0000;
    applyReset();
  endtask

  typedef struct {
    logic        z, c, n;
    logic [3:0]  cond;
    logic [15:0] expPc;
  } jmpCase_t;

  jmpCase_t jmpCases [9];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    jmpCases[0] = '{1'b1, 1'b0, 1'b0, 4'd2, 16'h0003};
    jmpCases[1] = '{1'b0, 1'b0, 1'b0, 4'd2, 16'h0040};
    jmpCases[2] = '{1'b1, 1'b0, 1'b0, 4'd1, 16'h0040};
    jmpCases[3] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0040};
    jmpCases[4] = '{1'b1, 1'b1, 1'b1, 4'd6, 16'h0003};
    jmpCases[5] = '{1'b0, 1'b1, 1'b0, 4'd3, 16'h0040};
    jmpCases[6] = '{1'b0, 1'b1, 1'b0, 4'd4, 16'h0003};
    jmpCases[7] = '{1'b0, 1'b0, 1'b1, 4'd5, 16'h0040};
    jmpCases[8] = '{1'b0, 1'b0, 1'b0, 4'd5, 16'h0003};

    // MOV b <- c with reset-state checks
    applyStimulus(16'h1120, 16'h0000, 16'h0000, 16'h0000);
    checkOutput("rst_flags", 32'(flags), 32'h0);
    checkOutput("rst_we", 32'(writeEn), 32'h0);
    checkOutput("rst_aluop", 32'(aluOp), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_pc", 32'(romAddr), 32'h0000);
    checkOutput("rst_pc_wrapinst", 32'(romAddrW), 32'hFFFF);
    waitCycles(1);
    checkOutput("mov_decode_flags", 32'(flags), 32'h0);
    waitCycles(1);
    checkOutput("mov_exec_flags", 32'(flags), 32'h0000_4002);
    checkOutput("mov_exec_we", 32'(writeEn), 32'h1);
    waitCycles(1);
    checkOutput("mov_after_pc", 32'(romAddr), 32'h0001);
    checkOutput("mov_after_flags", 32'(flags), 32'h0);
    checkOutput("wrap_pc", 32'(romAddrW), 32'h0000);

    // LDI a, 0xBEEF
    applyStimulus(16'h3000, 16'hBEEF, 16'h0000, 16'h0000);
    waitCycles(2);
    checkOutput("ldi_operand_flags", 32'(flags), 32'h0);
    waitCycles(1);
    checkOutput("ldi_exec_flags", 32'(flags), 32'h0020_0001);
    checkOutput("ldi_exec_rom", 32'(romData), 32'hBEEF);
    checkOutput("ldi_exec_we", 32'(writeEn), 32'h1);
    waitCycles(1);
    checkOutput("ldi_after_pc", 32'(romAddr), 32'h0002);

    // ALU a <- b (op 3) followed by a conditional JMP to 0x0040
    for (int k = 0; k < 9; k++) begin
      aluZero  = jmpCases[k].z;
      aluCarry = jmpCases[k].c;
      aluNeg   = jmpCases[k].n;
      applyStimulus(16'h2013, {4'h4, jmpCases[k].cond, 8'h00}, 16'h0040, 16'h0000);
      waitCycles(2);
      if (k == 0) begin
        checkOutput("alu_exec_flags", 32'(flags), 32'h0010_2001);
        checkOutput("alu_exec_op", 32'(aluOp), 32'h3);
      end
      waitCycles(4);
      checkOutput($sformatf("jmp%0d_exec_flags", k), 32'(flags), 32'h0080_0000);
      checkOutput($sformatf("jmp%0d_exec_we", k), 32'(writeEn), 32'h0);
      waitCycles(1);
      checkOutput($sformatf("jmp%0d_pc", k), 32'(romAddr), 32'(jmpCases[k].expPc));
    end
    aluZero = 1'b0; aluCarry = 1'b0; aluNeg = 1'b0;

    // Illegal dst/src codes, and src 12 selecting the 'in' output
    applyStimulus(16'h1DE0, 16'h17C0, 16'h0000, 16'h0000);
    waitCycles(2);
    checkOutput("illegal_flags", 32'(flags), 32'h0);
    checkOutput("illegal_we", 32'(writeEn), 32'h1);
    waitCycles(3);
    checkOutput("mov_h_in_flags", 32'(flags), 32'h0100_0080);

    // Reset asserted in the middle of EXEC
    applyStimulus(16'h1120, 16'h0000, 16'h0000, 16'h0000);
    waitCycles(2);
    rst_n = 1'b0;
    waitCycles(1);
    checkOutput("midrst_we", 32'(writeEn), 32'h0);
    checkOutput("midrst_flags", 32'(flags), 32'h0);
    checkOutput("midrst_pc", 32'(romAddr), 32'h0000);
    rst_n = 1'b1;

    // HALT is absorbing until reset
    applyStimulus(16'hF000, 16'h1120, 16'h0000, 16'h0000);
    waitCycles(1);
    checkOutput("halt_decode_halted", 32'(halted), 32'h0);
    waitCycles(1);
    checkOutput("halt_halted", 32'(halted), 32'h1);
    for (int i = 0; i < 10; i++) begin
      waitCycles(1);
      checkOutput($sformatf("halt_hold%0d_flags", i), 32'(flags), 32'h0);
      checkOutput($sformatf("halt_hold%0d_halted", i), 32'(halted), 32'h1);
    end
    rst_n = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
    checkOutput("halt_rst_halted", 32'(halted), 32'h0);
    checkOutput("halt_rst_pc", 32'(romAddr), 32'h0000);
    waitCycles(2);
    checkOutput("halt_rst_fetch_again", 32'(halted), 32'h1);

`ifdef SINGLE_STEP_EN
    // Frozen in FETCH until a single step pulse
    step = 1'b0;
    applyStimulus(16'h1120, 16'h1120, 16'h0000, 16'h0000);
    waitCycles(5);
    checkOutput("step_frozen_pc", 32'(romAddr), 32'h0000);
    checkOutput("step_frozen_flags", 32'(flags), 32'h0);
    step = 1'b1;
    waitCycles(1);
    step = 1'b0;
    waitCycles(1);
    checkOutput("step_exec_flags", 32'(flags), 32'h0000_4002);
    waitCycles(1);
    checkOutput("step_after_pc", 32'(romAddr), 32'h0001);
    waitCycles(4);
    checkOutput("step_hold_pc", 32'(romAddr), 32'h0001);
    checkOutput("step_hold_flags", 32'(flags), 32'h0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
